// File: rtl/sram_mn_pkg.sv
// Shared types and helpers for the row/k burst SRAM: FIFO entry, FSM states,
// conflict-policy codes and the row/k to linear address mapping.
package sram_mn_pkg;

   localparam int unsigned POL_OLD = 0;
   localparam int unsigned POL_NEW = 1;

   // Widest word the output buffer carries; narrower DATA_W is zero-extended.
   localparam int unsigned WORD_W = 32;

   typedef struct packed {
      logic [WORD_W-1:0] data;
      logic              last;
   } rd_entry_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } rq_state_t;

   function automatic int unsigned lin_addr(input int unsigned row,
                                            input int unsigned k,
                                            input int unsigned kmax);
      return row * kmax + k;
   endfunction

endpackage

// File: rtl/sram_mem_mn_burst_if.sv
// Write port, burst request channel and read stream of the row/k burst SRAM.
interface sram_mem_mn_burst_if #(
   parameter int unsigned ROW_W  = 3,
   parameter int unsigned K_W    = 10,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned LEN_W  = K_W + 1;
   localparam int unsigned BYTE_W = DATA_W / 8;

   logic              wr_en;
   logic [ROW_W-1:0]  wr_row;
   logic [K_W-1:0]    wr_k;
   logic [DATA_W-1:0] wr_wdata;
   logic [BYTE_W-1:0] wr_wmask;

   logic              rq_valid;
   logic              rq_ready;
   logic [ROW_W-1:0]  rq_row;
   logic [K_W-1:0]    rq_k;
   logic [LEN_W-1:0]  rq_len;

   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;

   logic              busy;
   logic              err;

   modport master (
      output wr_en, wr_row, wr_k, wr_wdata, wr_wmask,
      output rq_valid, rq_row, rq_k, rq_len,
      output rd_ready,
      input  rq_ready, rd_valid, rd_data, rd_last, busy, err
   );

   modport slave (
      input  wr_en, wr_row, wr_k, wr_wdata, wr_wmask,
      input  rq_valid, rq_row, rq_k, rq_len,
      input  rd_ready,
      output rq_ready, rd_valid, rd_data, rd_last, busy, err
   );

endinterface

// File: rtl/sram_rd_fifo.sv
// Show-ahead output buffer: head entry is visible whenever the FIFO is non-empty.
module sram_rd_fifo
   import sram_mn_pkg::*;
#(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  rd_entry_t        din,
   input  logic             pop,
   output rd_entry_t        dout,
   output logic             valid,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   rd_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q;
   logic [PTR_W-1:0] rptr_q;
   logic [CNT_W-1:0] cnt_q;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Storage needs no reset; occupancy gates everything visible.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) begin
            wptr_q <= ptr_inc(wptr_q);
         end
         if (pop) begin
            rptr_q <= ptr_inc(rptr_q);
         end
         cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign valid = (cnt_q != '0);
   assign dout  = valid ? mem_q[rptr_q] : '0;
   assign count = cnt_q;

endmodule

// File: rtl/sram_mem_mn_burst.sv
// Row/k addressed word memory with an independent masked write port and a
// credit-throttled row-burst read engine feeding a back-pressurable stream.
module sram_mem_mn_burst
   import sram_mn_pkg::*;
#(
   parameter int unsigned M               = 8,
   parameter int unsigned KMAX            = 1024,
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned RD_LAT          = 1,
   parameter int unsigned CONFLICT_POLICY = POL_NEW
) (
   input  logic               clk,
   input  logic               rst,
   sram_mem_mn_burst_if.slave bus
);

   localparam int unsigned BYTE_W = DATA_W / 8;
   localparam int unsigned ROW_W  = (M > 1) ? $clog2(M) : 1;
   localparam int unsigned K_W    = (KMAX > 1) ? $clog2(KMAX) : 1;
   localparam int unsigned LEN_W  = K_W + 1;
   localparam int unsigned WORDS  = M * KMAX;
   localparam int unsigned A_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int unsigned DEPTH  = RD_LAT + 2;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem [WORDS];

   rq_state_t         state_q, state_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [K_W-1:0]    k_q, k_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic              issue;
   logic              issue_last;
   logic              rq_err;

   logic              wr_row_ok, wr_k_ok, rq_row_ok, rq_k_ok;
   logic              wr_ok, wr_err, rq_ok;
   logic [A_W-1:0]    wr_addr, rd_addr;
   logic [DATA_W-1:0] rd_word;

   rd_entry_t         issue_ent, push_ent, head_ent;
   logic              push_vld;
   logic              fifo_valid, pop;
   logic [CNT_W-1:0]  fifo_cnt;
   logic [CNT_W-1:0]  in_flight_q;
   logic              credit_ok;
   logic              err_q;

   // Range checks collapse to constants when the index space is exactly filled.
   if (M == (1 << ROW_W)) begin : g_row_full
      assign wr_row_ok = 1'b1;
      assign rq_row_ok = 1'b1;
   end else begin : g_row_chk
      assign wr_row_ok = (bus.wr_row < ROW_W'(M));
      assign rq_row_ok = (bus.rq_row < ROW_W'(M));
   end

   if (KMAX == (1 << K_W)) begin : g_k_full
      assign wr_k_ok = 1'b1;
      assign rq_k_ok = 1'b1;
   end else begin : g_k_chk
      assign wr_k_ok = (bus.wr_k < K_W'(KMAX));
      assign rq_k_ok = (bus.rq_k < K_W'(KMAX));
   end

   assign wr_ok   = bus.wr_en && wr_row_ok && wr_k_ok;
   assign wr_err  = bus.wr_en && !(wr_row_ok && wr_k_ok);
   assign rq_ok   = rq_row_ok && rq_k_ok && (bus.rq_len != '0);
   assign wr_addr = A_W'(lin_addr(32'(bus.wr_row), 32'(bus.wr_k), KMAX));
   assign rd_addr = A_W'(lin_addr(32'(row_q), 32'(k_q), KMAX));

   // Masked byte write, committed at the sampling edge.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         for (int unsigned b = 0; b < BYTE_W; b++) begin
            if (bus.wr_wmask[b]) begin
               mem[wr_addr][b*8 +: 8] <= bus.wr_wdata[b*8 +: 8];
            end
         end
      end
   end

   // Array read; under POL_NEW a same-cycle write to the same word is forwarded.
   always_comb begin
      rd_word = mem[rd_addr];
      if (CONFLICT_POLICY == POL_NEW && wr_ok && (wr_addr == rd_addr)) begin
         for (int unsigned b = 0; b < BYTE_W; b++) begin
            if (bus.wr_wmask[b]) begin
               rd_word[b*8 +: 8] = bus.wr_wdata[b*8 +: 8];
            end
         end
      end
   end

   // Never issue more words than the output buffer can absorb.
   assign credit_ok = ((in_flight_q + fifo_cnt) < CNT_W'(DEPTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         k_q     <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         k_q     <= k_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      k_d        = k_q;
      rem_d      = rem_q;
      issue      = 1'b0;
      issue_last = 1'b0;
      rq_err     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.rq_valid) begin
               if (rq_ok) begin
                  state_d = ST_BURST;
                  row_d   = bus.rq_row;
                  k_d     = bus.rq_k;
                  rem_d   = bus.rq_len;
               end else begin
                  rq_err = 1'b1;
               end
            end
         end
         ST_BURST: begin
            if (credit_ok) begin
               issue = 1'b1;
               k_d   = (k_q == K_W'(KMAX - 1)) ? '0 : k_q + K_W'(1);
               rem_d = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  issue_last = 1'b1;
                  state_d    = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign issue_ent.data = WORD_W'(rd_word);
   assign issue_ent.last = issue_last;

   // RD_LAT-1 delay stages between the array read and the buffer.
   if (RD_LAT == 1) begin : g_lat1
      assign push_vld = issue;
      assign push_ent = issue_ent;
   end else begin : g_pipe
      logic      vld_sr [RD_LAT-1];
      rd_entry_t ent_sr [RD_LAT-1];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int unsigned i = 0; i < RD_LAT - 1; i++) begin
               vld_sr[i] <= 1'b0;
               ent_sr[i] <= '0;
            end
         end else begin
            vld_sr[0] <= issue;
            ent_sr[0] <= issue_ent;
            for (int unsigned i = 1; i < RD_LAT - 1; i++) begin
               vld_sr[i] <= vld_sr[i-1];
               ent_sr[i] <= ent_sr[i-1];
            end
         end
      end

      assign push_vld = vld_sr[RD_LAT-2];
      assign push_ent = ent_sr[RD_LAT-2];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_flight_q <= '0;
         err_q       <= 1'b0;
      end else begin
         in_flight_q <= in_flight_q + CNT_W'(issue) - CNT_W'(push_vld);
         err_q       <= wr_err || rq_err;
      end
   end

   assign pop = fifo_valid && bus.rd_ready;

   sram_rd_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_vld),
      .din   (push_ent),
      .pop   (pop),
      .dout  (head_ent),
      .valid (fifo_valid),
      .count (fifo_cnt)
   );

   assign bus.rq_ready = (state_q == ST_IDLE);
   assign bus.rd_valid = fifo_valid;
   assign bus.rd_data  = DATA_W'(head_ent.data);
   assign bus.rd_last  = head_ent.last;
   assign bus.busy     = (state_q == ST_BURST) || (in_flight_q != '0) || fifo_valid;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_sram_mem_mn_burst.sv
// Scoreboard bench: two instances (RD_LAT 1 / new-data policy, RD_LAT 2 / old-data
// policy) share stimulus; per-instance queues hold the hand-computed words.
module tb_sram_mem_mn_burst;

   localparam int unsigned M      = 5;
   localparam int unsigned KMAX   = 12;
   localparam int unsigned ROW_W  = 3;
   localparam int unsigned K_W    = 4;
   localparam int unsigned LEN_W  = 5;
   localparam int unsigned DATA_W = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic              wr_en;
   logic [ROW_W-1:0]  wr_row;
   logic [K_W-1:0]    wr_k;
   logic [DATA_W-1:0] wr_wdata;
   logic [3:0]        wr_wmask;
   logic              rq_valid;
   logic [ROW_W-1:0]  rq_row;
   logic [K_W-1:0]    rq_k;
   logic [LEN_W-1:0]  rq_len;
   logic              rd_ready;

   sram_mem_mn_burst_if #(.ROW_W(ROW_W), .K_W(K_W), .DATA_W(DATA_W)) bif1 (), bif0 ();

   assign bif1.wr_en = wr_en;       assign bif0.wr_en = wr_en;
   assign bif1.wr_row = wr_row;     assign bif0.wr_row = wr_row;
   assign bif1.wr_k = wr_k;         assign bif0.wr_k = wr_k;
   assign bif1.wr_wdata = wr_wdata; assign bif0.wr_wdata = wr_wdata;
   assign bif1.wr_wmask = wr_wmask; assign bif0.wr_wmask = wr_wmask;
   assign bif1.rq_valid = rq_valid; assign bif0.rq_valid = rq_valid;
   assign bif1.rq_row = rq_row;     assign bif0.rq_row = rq_row;
   assign bif1.rq_k = rq_k;         assign bif0.rq_k = rq_k;
   assign bif1.rq_len = rq_len;     assign bif0.rq_len = rq_len;
   assign bif1.rd_ready = rd_ready; assign bif0.rd_ready = rd_ready;

   sram_mem_mn_burst #(
      .M(M), .KMAX(KMAX), .DATA_W(DATA_W), .RD_LAT(1), .CONFLICT_POLICY(1)
   ) u_dut1 (.clk(clk), .rst(rst), .bus(bif1));

   sram_mem_mn_burst #(
      .M(M), .KMAX(KMAX), .DATA_W(DATA_W), .RD_LAT(2), .CONFLICT_POLICY(0)
   ) u_dut0 (.clk(clk), .rst(rst), .bus(bif0));

   logic [32:0] q1 [$];
   logic [32:0] q0 [$];
   int n_vec;
   int n_bad;

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic pop_cmp(input int which, input logic [31:0] d, input logic l);
      logic [32:0] e;
      if ((which == 1 && q1.size() == 0) || (which == 0 && q0.size() == 0)) begin
         n_vec++;
         n_bad++;
         $display("FAIL dut%0d_unexpected_word: got %h last=%b, expected no word", which, d, l);
      end else begin
         e = (which == 1) ? q1.pop_front() : q0.pop_front();
         chk($sformatf("dut%0d_word", which), {l, d}, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int unsigned row, input int unsigned k,
                     input logic [31:0] d, input logic [3:0] m);
      wr_en    = 1'b1;
      wr_row   = ROW_W'(row);
      wr_k     = K_W'(k);
      wr_wdata = d;
      wr_wmask = m;
      tick();
      wr_en = 1'b0;
   endtask

   // Holds rq_valid for one cycle; returns in the cycle after the accepting edge.
   task automatic req(input int unsigned row, input int unsigned k, input int unsigned len);
      rq_valid = 1'b1;
      rq_row   = ROW_W'(row);
      rq_k     = K_W'(k);
      rq_len   = LEN_W'(len);
      tick();
      rq_valid = 1'b0;
   endtask

   task automatic exp2(input logic [31:0] d1, input logic [31:0] d0, input logic l);
      q1.push_back({l, d1});
      q0.push_back({l, d0});
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (!bif1.busy && !bif0.busy && q1.size() == 0 && q0.size() == 0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      n_vec++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s_drain: got %0d/%0d words outstanding, expected 0/0", name, q1.size(), q0.size());
         q1.delete();
         q0.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_vec = 0; n_bad = 0;
      wr_en = 0; wr_row = '0; wr_k = '0; wr_wdata = '0; wr_wmask = '0;
      rq_valid = 0; rq_row = '0; rq_k = '0; rq_len = '0;
      rd_ready = 1'b1;
      rst = 1'b1;

      fork
         forever begin
            @(negedge clk);
            if (!rst && bif1.rd_valid && rd_ready) pop_cmp(1, bif1.rd_data, bif1.rd_last);
         end
         forever begin
            @(negedge clk);
            if (!rst && bif0.rd_valid && rd_ready) pop_cmp(0, bif0.rd_data, bif0.rd_last);
         end
      join_none

      repeat (3) tick();
      chk("rst_rq_ready", 33'(bif1.rq_ready), 33'd1);
      chk("rst_rd_valid", 33'(bif1.rd_valid), 33'd0);
      chk("rst_rd_last",  33'(bif1.rd_last),  33'd0);
      chk("rst_rd_data",  33'(bif1.rd_data),  33'd0);
      chk("rst_busy",     33'(bif1.busy),     33'd0);
      chk("rst_err",      33'(bif1.err),      33'd0);
      chk("rst_dut0_rdy", 33'({bif0.rq_ready, bif0.busy}), 33'b10);
      rst = 1'b0;
      tick();

      // Row 2 burst: latency, streaming, rd_last placement and rq_ready timing.
      for (int k = 0; k < 8; k++) wr(2, k, 32'h100 + k, 4'hF);
      for (int k = 0; k < 8; k++) exp2(32'h100 + k, 32'h100 + k, k == 7);
      req(2, 0, 8);
      chk("lat1_early",   33'(bif1.rd_valid), 33'd0);
      chk("burst_rq_low", 33'(bif1.rq_ready), 33'd0);
      tick();
      chk("lat1_first",   33'({bif1.rd_valid, bif1.rd_data}), {1'b1, 32'h100});
      chk("lat2_early",   33'(bif0.rd_valid), 33'd0);
      tick();
      chk("lat2_first",   33'({bif0.rd_valid, bif0.rd_data}), {1'b1, 32'h100});
      repeat (5) tick();
      chk("rq_low_last_issue", 33'(bif1.rq_ready), 33'd0);
      tick();
      chk("word8_no_bubble", {bif1.rd_last, bif1.rd_data}, {1'b1, 32'h107});
      chk("rq_ready_rise",   33'(bif1.rq_ready), 33'd1);
      wait_idle("burst8");

      // Column wrap within row 1 (KMAX = 12).
      wr(1, 10, 32'h20A, 4'hF);
      wr(1, 11, 32'h20B, 4'hF);
      wr(1, 0,  32'h200, 4'hF);
      wr(1, 1,  32'h201, 4'hF);
      exp2(32'h20A, 32'h20A, 1'b0);
      exp2(32'h20B, 32'h20B, 1'b0);
      exp2(32'h200, 32'h200, 1'b0);
      exp2(32'h201, 32'h201, 1'b1);
      req(1, 10, 4);
      wait_idle("wrap");

      // Back-pressure: alternating ready, a 10-cycle stall, then alternating again.
      for (int k = 0; k < 8; k++) wr(4, k, 32'h400 + k, 4'hF);
      for (int k = 0; k < 8; k++) exp2(32'h400 + k, 32'h400 + k, k == 7);
      req(4, 0, 8);
      for (int i = 0; i < 6; i++) begin
         rd_ready = (i % 2 == 0);
         tick();
      end
      rd_ready = 1'b0;
      repeat (10) tick();
      chk("stall_hold", 33'({bif1.rd_valid, bif1.busy, bif0.rd_valid}), 33'b111);
      for (int i = 0; i < 8; i++) begin
         rd_ready = (i % 2 == 0);
         tick();
      end
      rd_ready = 1'b1;
      wait_idle("backpressure");

      // Same-cycle read/write conflict at (3,5), then a later re-read.
      wr(3, 5, 32'hAAAA_AAAA, 4'hF);
      exp2(32'hAAAA_5555, 32'hAAAA_AAAA, 1'b1);
      req(3, 5, 1);
      wr(3, 5, 32'h5555_5555, 4'b0011);
      wait_idle("conflict");
      exp2(32'hAAAA_5555, 32'hAAAA_5555, 1'b1);
      req(3, 5, 1);
      wait_idle("conflict_reread");

      // Rejected requests: len 0, row M, k KMAX.
      req(0, 0, 0);
      chk("err_len0", 33'({bif1.err, bif0.err, bif1.rq_ready, bif1.rd_valid}), 33'b1110);
      tick();
      chk("err_len0_clear", 33'({bif1.err, bif0.err}), 33'b00);
      req(M, 0, 4);
      chk("err_row", 33'({bif1.err, bif0.err, bif1.rq_ready, bif1.busy}), 33'b1110);
      tick();
      chk("err_row_clear", 33'({bif1.err, bif0.err}), 33'b00);
      req(0, KMAX, 4);
      chk("err_k", 33'({bif1.err, bif0.err, bif1.rq_ready, bif1.busy}), 33'b1110);
      tick();

      // Out-of-range write (2,KMAX) would alias onto (3,0) if not rejected.
      wr(3, 0, 32'h300, 4'hF);
      wr(2, KMAX, 32'hDEAD_BEEF, 4'hF);
      chk("err_wr", 33'({bif1.err, bif0.err}), 33'b11);
      tick();
      chk("err_wr_clear", 33'({bif1.err, bif0.err}), 33'b00);
      exp2(32'h300, 32'h300, 1'b1);
      req(3, 0, 1);
      wait_idle("wr_reject");

      // Reset after three words of an 8-word burst, then repeat the burst.
      for (int k = 0; k < 8; k++) exp2(32'h100 + k, 32'h100 + k, k == 7);
      req(2, 0, 8);
      for (int i = 0; i < 40 && q1.size() > 5; i++) begin
         @(negedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_outputs", {bif1.rd_valid, bif1.rd_last, bif1.busy, bif1.rq_ready, bif0.rd_valid, 28'd0},
          {5'b00010, 28'd0});
      chk("midrst_data", 33'(bif1.rd_data), 33'd0);
      q1.delete();
      q0.delete();
      repeat (2) tick();
      rst = 1'b0;
      tick();
      for (int k = 0; k < 8; k++) exp2(32'h100 + k, 32'h100 + k, k == 7);
      req(2, 0, 8);
      wait_idle("after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
